// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - truth-table logic unit with reduction modes and result FIFO
module logic_unit_pipe #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [3:0]       logic_sel,
  input  logic [1:0]       mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [1:0] MODE_BIT = 2'b00;
  localparam logic [1:0] MODE_OR  = 2'b01;
  localparam logic [1:0] MODE_AND = 2'b10;

  logic [WIDTH-1:0] mem_result_q [DEPTH];
  logic             mem_zero_q   [DEPTH];
  logic [TAG_W-1:0] mem_tag_q    [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic [WIDTH-1:0] bits;
  logic [WIDTH-1:0] result_d;
  logic             zero_d;
  logic             push;
  logic             pop;

  // Per-bit truth-table lookup indexed by {op2, op1}
  always_comb begin
    bits = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bits[i] = logic_sel[{op2[i], op1[i]}];
    end
  end

  // Select bitwise result or a single-bit reduction in bit 0
  always_comb begin
    result_d = '0;
    case (mode)
      MODE_BIT: result_d = bits;
      MODE_OR:  result_d[0] = |bits;
      MODE_AND: result_d[0] = &bits;
      default:  result_d[0] = ^bits;
    endcase
    zero_d = (result_d == '0);
  end

  // Full FIFO refuses input regardless of a same-cycle pop, keeping in_ready off the out_ready path
  assign in_ready  = ~rst & (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Next-state for pointers and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; reset discards everything including a same-cycle pop
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage is written only on an accepted push; contents need no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem_result_q[wr_ptr_q] <= result_d;
      mem_zero_q[wr_ptr_q]   <= zero_d;
      mem_tag_q[wr_ptr_q]    <= in_tag;
    end
  end

  // Head outputs forced to zero whenever the FIFO is empty
  always_comb begin
    out_result = '0;
    out_zero   = 1'b0;
    out_tag    = '0;
    if (out_valid) begin
      out_result = mem_result_q[rd_ptr_q];
      out_zero   = mem_zero_q[rd_ptr_q];
      out_tag    = mem_tag_q[rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb/tb_logic_unit_pipe.sv - directed table-driven bench for logic_unit_pipe
module tb_logic_unit_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [3:0]  logic_sel;
  logic [1:0]  mode;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic [3:0]  out_tag;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  sel;
    logic [1:0]  md;
    logic [31:0] res;
    logic        zero;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  logic_unit_pipe #(.WIDTH(32), .DEPTH(2), .TAG_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op1        (op1),
    .op2        (op2),
    .logic_sel  (logic_sel),
    .mode       (mode),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_tag    (out_tag)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s,
                       input logic [1:0] m, input logic [3:0] t);
    op1 = a; op2 = b; logic_sel = s; mode = m; in_tag = t;
  endtask

  task automatic chk_head(input string nm, input logic [31:0] res, input logic z, input logic [3:0] t);
    chk({nm, "_valid"}, 32'(out_valid), 32'd1);
    chk({nm, "_result"}, out_result, res);
    chk({nm, "_zero"}, 32'(out_zero), 32'(z));
    chk({nm, "_tag"}, 32'(out_tag), 32'(t));
  endtask

  task automatic chk_empty(input string nm);
    chk({nm, "_valid"}, 32'(out_valid), 32'd0);
    chk({nm, "_result"}, out_result, 32'd0);
    chk({nm, "_zero"}, 32'(out_zero), 32'd0);
    chk({nm, "_tag"}, 32'(out_tag), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    step(); step();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk_empty("rst_out");
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    vecs[0]  = '{32'hF0F01234, 32'hFF0000FF, 4'b1000, 2'b00, 32'hF0000034, 1'b0};
    vecs[1]  = '{32'hF0F01234, 32'hFF0000FF, 4'b1110, 2'b00, 32'hFFF012FF, 1'b0};
    vecs[2]  = '{32'hF0F01234, 32'hFF0000FF, 4'b0110, 2'b00, 32'h0FF012CB, 1'b0};
    vecs[3]  = '{32'hF0F01234, 32'hFF0000FF, 4'b0001, 2'b00, 32'h000FED00, 1'b0};
    vecs[4]  = '{32'hF0F01234, 32'hFF0000FF, 4'b1001, 2'b00, 32'hF00FED34, 1'b0};
    vecs[5]  = '{32'hF0F01234, 32'hFF0000FF, 4'b1010, 2'b00, 32'hF0F01234, 1'b0};
    vecs[6]  = '{32'hF0F01234, 32'hFF0000FF, 4'b0101, 2'b00, 32'h0F0FEDCB, 1'b0};
    vecs[7]  = '{32'hF0F01234, 32'hFF0000FF, 4'b0000, 2'b00, 32'h00000000, 1'b1};
    vecs[8]  = '{32'hF0F01234, 32'hFF0000FF, 4'b1111, 2'b00, 32'hFFFFFFFF, 1'b0};
    vecs[9]  = '{32'hF0F01234, 32'hFF0000FF, 4'b0010, 2'b00, 32'h00F01200, 1'b0};
    vecs[10] = '{32'hF0F01234, 32'hFF0000FF, 4'b0100, 2'b00, 32'h0F0000CB, 1'b0};
    vecs[11] = '{32'h00000100, 32'h00000100, 4'b1000, 2'b01, 32'h00000001, 1'b0};
    vecs[12] = '{32'h00000100, 32'h00000100, 4'b1000, 2'b10, 32'h00000000, 1'b1};
    vecs[13] = '{32'h00000100, 32'h00000100, 4'b1000, 2'b11, 32'h00000001, 1'b0};
    vecs[14] = '{32'h80000001, 32'h80000001, 4'b1000, 2'b11, 32'h00000000, 1'b1};
    vecs[15] = '{32'h12345678, 32'h9ABCDEF0, 4'b1111, 2'b10, 32'h00000001, 1'b0};
    vecs[16] = '{32'hF0F01234, 32'h00000000, 4'b1010, 2'b11, 32'h00000001, 1'b0};
    vecs[17] = '{32'h00000000, 32'h00000000, 4'b1000, 2'b01, 32'h00000000, 1'b1};

    drive('0, '0, '0, '0, '0);
    do_reset();

    // Table sweep: each vector is checked one cycle after acceptance while the next is offered
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      logic [3:0] t;
      t = i[3:0];
      in_valid = 1'b1;
      drive(vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].md, t);
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
      step();
      chk_head($sformatf("vec%0d", i), vecs[i].res, vecs[i].zero, t);
    end
    in_valid = 1'b0;
    step();
    chk_empty("sweep_drained");

    // Back-pressure: third offer refused until one pop
    out_ready = 1'b0;
    in_valid = 1'b1;
    drive(32'h11, 32'h0, 4'b1010, 2'b00, 4'd1);
    step();
    chk_head("bp_first", 32'h11, 1'b0, 4'd1);
    chk("bp_rdy_after1", 32'(in_ready), 32'd1);
    drive(32'h22, 32'h0, 4'b1010, 2'b00, 4'd2);
    step();
    chk("bp_full_in_ready", 32'(in_ready), 32'd0);
    drive(32'h33, 32'h0, 4'b1010, 2'b00, 4'd3);
    step();
    chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
    chk_head("bp_hold", 32'h11, 1'b0, 4'd1);
    out_ready = 1'b1;
    #1;
    chk("bp_no_comb_ready", 32'(in_ready), 32'd0);
    step();
    out_ready = 1'b0;
    #1;
    chk("bp_rdy_after_pop", 32'(in_ready), 32'd1);
    chk_head("bp_second", 32'h22, 1'b0, 4'd2);
    step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk_head("bp_drain2", 32'h22, 1'b0, 4'd2);
    step();
    chk_head("bp_drain3", 32'h33, 1'b0, 4'd3);
    step();
    chk_empty("bp_drained");

    // Streaming: one accept and one pop per cycle
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      logic [3:0] t;
      t = i[3:0];
      in_valid = 1'b1;
      drive(32'(i), 32'h0, 4'b1010, 2'b00, t);
      #1;
      chk($sformatf("stream%0d_in_ready", i), 32'(in_ready), 32'd1);
      step();
      chk_head($sformatf("stream%0d", i), 32'(i), (i == 0), t);
    end
    in_valid = 1'b0;
    step();
    chk_empty("stream_drained");

    // Reset while full with a push and a pop offered
    out_ready = 1'b0;
    in_valid = 1'b1;
    drive(32'hAA, 32'h0, 4'b1010, 2'b00, 4'd5);
    step();
    drive(32'hBB, 32'h0, 4'b1010, 2'b00, 4'd6);
    step();
    chk("mid_full_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    out_ready = 1'b1;
    drive(32'hCC, 32'h0, 4'b1010, 2'b00, 4'd7);
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk_empty("mid_after_rst");
    chk("mid_after_rst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("mid_stays_empty%0d", i), 32'(out_valid), 32'd0);
    end

    // Pointer wrap: push, then pop the next cycle, seven times
    for (int i = 0; i < 7; i++) begin
      logic [31:0] v;
      logic [3:0]  s;
      logic [31:0] exp_r;
      v = 32'h1111 * (i + 1);
      s = (i == 3) ? 4'b0000 : 4'b1010;
      exp_r = (i == 3) ? 32'h0 : v;
      out_ready = 1'b0;
      in_valid = 1'b1;
      drive(v, 32'h0, s, 2'b00, 4'(i + 8));
      step();
      in_valid = 1'b0;
      out_ready = 1'b1;
      chk_head($sformatf("wrap%0d", i), exp_r, (i == 3), 4'(i + 8));
      step();
      chk($sformatf("wrap%0d_popped", i), 32'(out_valid), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
